// File: rtl/rgb_lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rgb_lcd_pkg
// Purpose  : Default panel timing, RGB565 pixel type and colour-bar palette.
// Revision : 1.0 - initial release
// ============================================================================
package rgb_lcd_pkg;

   typedef logic [15:0] rgb565_t;

   localparam int unsigned H_CNT_W = 11;
   localparam int unsigned V_CNT_W = 10;

   localparam int unsigned RGB_H_ACTIVE = 800;
   localparam int unsigned RGB_H_FRONT  = 40;
   localparam int unsigned RGB_H_SYNC   = 48;
   localparam int unsigned RGB_H_BACK   = 40;
   localparam int unsigned RGB_V_ACTIVE = 480;
   localparam int unsigned RGB_V_FRONT  = 13;
   localparam int unsigned RGB_V_SYNC   = 3;
   localparam int unsigned RGB_V_BACK   = 29;

   localparam rgb565_t RGB_WHITE   = 16'hFFFF;
   localparam rgb565_t RGB_YELLOW  = 16'hFFE0;
   localparam rgb565_t RGB_CYAN    = 16'h07FF;
   localparam rgb565_t RGB_GREEN   = 16'h07E0;
   localparam rgb565_t RGB_MAGENTA = 16'hF81F;
   localparam rgb565_t RGB_RED     = 16'hF800;
   localparam rgb565_t RGB_BLUE    = 16'h001F;
   localparam rgb565_t RGB_BLACK   = 16'h0000;

   // Bars run left to right, one per 128-pixel column group.
   function automatic rgb565_t rgb565_bar(input logic [2:0] idx);
      rgb565_t colour;
      colour = RGB_BLACK;
      case (idx)
         3'd0:    colour = RGB_WHITE;
         3'd1:    colour = RGB_YELLOW;
         3'd2:    colour = RGB_CYAN;
         3'd3:    colour = RGB_GREEN;
         3'd4:    colour = RGB_MAGENTA;
         3'd5:    colour = RGB_RED;
         3'd6:    colour = RGB_BLUE;
         default: colour = RGB_BLACK;
      endcase
      return colour;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_lcd_counter.sv
`default_nettype none
// ============================================================================
// Module   : rgb_lcd_counter
// Purpose  : Free-running pixel/line counters with active and sync windows.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_lcd_counter
   import rgb_lcd_pkg::*;
#(
   parameter int unsigned H_ACTIVE = RGB_H_ACTIVE,
   parameter int unsigned H_FRONT  = RGB_H_FRONT,
   parameter int unsigned H_SYNC   = RGB_H_SYNC,
   parameter int unsigned H_BACK   = RGB_H_BACK,
   parameter int unsigned V_ACTIVE = RGB_V_ACTIVE,
   parameter int unsigned V_FRONT  = RGB_V_FRONT,
   parameter int unsigned V_SYNC   = RGB_V_SYNC,
   parameter int unsigned V_BACK   = RGB_V_BACK
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   output logic [H_CNT_W-1:0] h_cnt_o,
   output logic [V_CNT_W-1:0] v_cnt_o,
   output logic               active_o,
   output logic               first_o,
   output logic               hs_win_o,
   output logic               vs_win_o
);

   localparam int unsigned c_h_total = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned c_v_total = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   if (c_h_total > 2048) begin : g_h_total_err
      $error("rgb_lcd_counter: H_TOTAL %0d does not fit an 11-bit counter", c_h_total);
   end
   if (c_v_total > 1024) begin : g_v_total_err
      $error("rgb_lcd_counter: V_TOTAL %0d does not fit a 10-bit counter", c_v_total);
   end

   // Window bounds carry one spare bit so a window ending exactly at 2048/1024 stays correct.
   localparam logic [H_CNT_W:0]   c_h_act      = (H_CNT_W+1)'(H_ACTIVE);
   localparam logic [H_CNT_W:0]   c_h_sync_beg = (H_CNT_W+1)'(H_ACTIVE + H_FRONT);
   localparam logic [H_CNT_W:0]   c_h_sync_end = (H_CNT_W+1)'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [H_CNT_W-1:0] c_h_last     = H_CNT_W'(c_h_total - 1);
   localparam logic [V_CNT_W:0]   c_v_act      = (V_CNT_W+1)'(V_ACTIVE);
   localparam logic [V_CNT_W:0]   c_v_sync_beg = (V_CNT_W+1)'(V_ACTIVE + V_FRONT);
   localparam logic [V_CNT_W:0]   c_v_sync_end = (V_CNT_W+1)'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [V_CNT_W-1:0] c_v_last     = V_CNT_W'(c_v_total - 1);

   logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d;
   logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d;
   logic [H_CNT_W:0]   h_ext;
   logic [V_CNT_W:0]   v_ext;

   always_comb begin
      h_cnt_d = h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == c_h_last) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == c_v_last) ? '0 : v_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   assign h_ext = {1'b0, h_cnt_q};
   assign v_ext = {1'b0, v_cnt_q};

   assign h_cnt_o  = h_cnt_q;
   assign v_cnt_o  = v_cnt_q;
   assign active_o = (h_ext < c_h_act) && (v_ext < c_v_act);
   assign first_o  = (h_cnt_q == '0) && (v_cnt_q == '0);
   assign hs_win_o = (h_ext >= c_h_sync_beg) && (h_ext < c_h_sync_end);
   assign vs_win_o = (v_ext >= c_v_sync_beg) && (v_ext < c_v_sync_end);

endmodule
`default_nettype wire

// File: rtl/rgb_lcd_timing.sv
`default_nettype none
// ============================================================================
// Module   : rgb_lcd_timing
// Purpose  : RGB parallel-panel timing generator with renderer request port.
//            RGB_LCD_TEST_PATTERN_EN adds the test_pattern colour-bar input.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_lcd_timing
   import rgb_lcd_pkg::*;
#(
   parameter int unsigned H_ACTIVE = RGB_H_ACTIVE,
   parameter int unsigned H_FRONT  = RGB_H_FRONT,
   parameter int unsigned H_SYNC   = RGB_H_SYNC,
   parameter int unsigned H_BACK   = RGB_H_BACK,
   parameter int unsigned V_ACTIVE = RGB_V_ACTIVE,
   parameter int unsigned V_FRONT  = RGB_V_FRONT,
   parameter int unsigned V_SYNC   = RGB_V_SYNC,
   parameter int unsigned V_BACK   = RGB_V_BACK,
   parameter logic        HS_POL   = 1'b0,
   parameter logic        VS_POL   = 1'b0
) (
   input  logic               clkin,
   input  logic               resetn,
`ifdef RGB_LCD_TEST_PATTERN_EN
   input  logic               test_pattern,
`endif
   output logic               pix_req,
   output logic [H_CNT_W-1:0] pix_x,
   output logic [V_CNT_W-1:0] pix_y,
   output logic               frame_start,
   input  logic [15:0]        pix_rgb,
   output logic               lcd_de,
   output logic               lcd_hs,
   output logic               lcd_vs,
   output logic [15:0]        lcd_rgb
);

   logic [H_CNT_W-1:0] h_cnt;
   logic [V_CNT_W-1:0] v_cnt;
   logic               cnt_active;
   logic               cnt_first;
   logic               cnt_hs_win;
   logic               cnt_vs_win;

   rgb_lcd_counter #(
      .H_ACTIVE (H_ACTIVE),
      .H_FRONT  (H_FRONT),
      .H_SYNC   (H_SYNC),
      .H_BACK   (H_BACK),
      .V_ACTIVE (V_ACTIVE),
      .V_FRONT  (V_FRONT),
      .V_SYNC   (V_SYNC),
      .V_BACK   (V_BACK)
   ) u_counter (
      .clk_i    (clkin),
      .rst_ni   (resetn),
      .h_cnt_o  (h_cnt),
      .v_cnt_o  (v_cnt),
      .active_o (cnt_active),
      .first_o  (cnt_first),
      .hs_win_o (cnt_hs_win),
      .vs_win_o (cnt_vs_win)
   );

   // Request stage: registered so every request output reads idle while in reset.
   logic               req_q, req_d;
   logic [H_CNT_W-1:0] x_q, x_d;
   logic [V_CNT_W-1:0] y_q, y_d;
   logic               fs_q, fs_d;
   logic               hs_win_q;
   logic               vs_win_q;

   always_comb begin
      req_d = cnt_active;
      x_d   = cnt_active ? h_cnt : '0;
      y_d   = cnt_active ? v_cnt : '0;
      fs_d  = cnt_first;
   end

   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         req_q    <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         fs_q     <= 1'b0;
         hs_win_q <= 1'b0;
         vs_win_q <= 1'b0;
      end else begin
         req_q    <= req_d;
         x_q      <= x_d;
         y_q      <= y_d;
         fs_q     <= fs_d;
         hs_win_q <= cnt_hs_win;
         vs_win_q <= cnt_vs_win;
      end
   end

`ifdef RGB_LCD_TEST_PATTERN_EN
   // Pattern select travels with the request so a switch lands on a pixel boundary.
   logic tp_q;

   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         tp_q <= 1'b0;
      end else begin
         tp_q <= test_pattern;
      end
   end
`endif

   // Panel stage: one cycle behind the request, in step with the returned pixel.
   rgb565_t rgb_d, rgb_q;
   logic    de_q;
   logic    hs_q;
   logic    vs_q;

   always_comb begin
      rgb_d = RGB_BLACK;
      if (req_q) begin
`ifdef RGB_LCD_TEST_PATTERN_EN
         rgb_d = tp_q ? rgb565_bar(x_q[9:7]) : pix_rgb;
`else
         rgb_d = pix_rgb;
`endif
      end
   end

   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         de_q  <= 1'b0;
         hs_q  <= ~HS_POL;
         vs_q  <= ~VS_POL;
         rgb_q <= RGB_BLACK;
      end else begin
         de_q  <= req_q;
         hs_q  <= hs_win_q ? HS_POL : ~HS_POL;
         vs_q  <= vs_win_q ? VS_POL : ~VS_POL;
         rgb_q <= rgb_d;
      end
   end

   assign pix_req     = req_q;
   assign pix_x       = x_q;
   assign pix_y       = y_q;
   assign frame_start = fs_q;
   assign lcd_de      = de_q;
   assign lcd_hs      = hs_q;
   assign lcd_vs      = vs_q;
   assign lcd_rgb     = rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_lcd_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_lcd_timing
// Purpose  : Self-checking bench for rgb_lcd_timing (full-width lines, short frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_lcd_timing;

   localparam int H_A = 800;
   localparam int H_F = 40;
   localparam int H_S = 48;
   localparam int H_B = 40;
   localparam int V_A = 6;
   localparam int V_F = 2;
   localparam int V_S = 3;
   localparam int V_B = 2;
   localparam int H_T = H_A + H_F + H_S + H_B;
   localparam int V_T = V_A + V_F + V_S + V_B;
   localparam int FRAME = H_T * V_T;

   localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                        16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   logic        clkin;
   logic        resetn;
   logic        tp_drive;
   logic        pix_req;
   logic [10:0] pix_x;
   logic [9:0]  pix_y;
   logic        frame_start;
   logic [15:0] pix_rgb;
   logic        lcd_de;
   logic        lcd_hs;
   logic        lcd_vs;
   logic [15:0] lcd_rgb;
   logic [15:0] salt;

   // Renderer: pixel word derived from the requested coordinate, scrambled per run.
   assign pix_rgb = {pix_y[4:0], pix_x} ^ salt;

   rgb_lcd_timing #(
      .H_ACTIVE (H_A), .H_FRONT (H_F), .H_SYNC (H_S), .H_BACK (H_B),
      .V_ACTIVE (V_A), .V_FRONT (V_F), .V_SYNC (V_S), .V_BACK (V_B),
      .HS_POL   (1'b0), .VS_POL (1'b0)
   ) dut (
      .clkin        (clkin),
      .resetn       (resetn),
`ifdef RGB_LCD_TEST_PATTERN_EN
      .test_pattern (tp_drive),
`endif
      .pix_req      (pix_req),
      .pix_x        (pix_x),
      .pix_y        (pix_y),
      .frame_start  (frame_start),
      .pix_rgb      (pix_rgb),
      .lcd_de       (lcd_de),
      .lcd_hs       (lcd_hs),
      .lcd_vs       (lcd_vs),
      .lcd_rgb      (lcd_rgb)
   );

   initial clkin = 1'b0;
   always #5 clkin = ~clkin;

   int   n_vec;
   int   n_bad;
   int   t;
   logic tp_used;
   logic tp_prev;
   logic stats_en;
   int   de_cnt, vs_cnt, hs_cnt;
   int   hs_first, vs_first, fs_first, fs_second;
   int   target;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_pix_req"}, 32'(pix_req), 32'd0);
      chk({tag, "_pix_x"}, 32'(pix_x), 32'd0);
      chk({tag, "_pix_y"}, 32'(pix_y), 32'd0);
      chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
      chk({tag, "_lcd_de"}, 32'(lcd_de), 32'd0);
      chk({tag, "_lcd_hs"}, 32'(lcd_hs), 32'd1);
      chk({tag, "_lcd_vs"}, 32'(lcd_vs), 32'd1);
      chk({tag, "_lcd_rgb"}, 32'(lcd_rgb), 32'd0);
   endtask

   // Reference: cycle t after release shows the request for position t of the frame
   // and the panel pins for position t-1; cycle 0 panel pins are still idle.
   task automatic check_model();
      int          p, r, c;
      logic        req_e, de_e, hs_e, vs_e;
      logic [15:0] rgb_e;
      p = t % FRAME;
      r = p / H_T;
      c = p % H_T;
      req_e = (r < V_A) && (c < H_A);
      chk("pix_req", 32'(pix_req), 32'(req_e));
      chk("pix_x", 32'(pix_x), req_e ? 32'(c) : 32'd0);
      chk("pix_y", 32'(pix_y), req_e ? 32'(r) : 32'd0);
      chk("frame_start", 32'(frame_start), 32'(p == 0));
      if (t == 0) begin
         de_e = 1'b0; hs_e = 1'b1; vs_e = 1'b1; rgb_e = 16'h0000;
      end else begin
         p = (t - 1) % FRAME;
         r = p / H_T;
         c = p % H_T;
         de_e  = (r < V_A) && (c < H_A);
         hs_e  = !((c >= H_A + H_F) && (c < H_A + H_F + H_S));
         vs_e  = !((r >= V_A + V_F) && (r < V_A + V_F + V_S));
         rgb_e = !de_e ? 16'h0000 : (tp_prev ? BARS[c / 128] : ({5'(r), 11'(c)} ^ salt));
      end
      chk("lcd_de", 32'(lcd_de), 32'(de_e));
      chk("lcd_hs", 32'(lcd_hs), 32'(hs_e));
      chk("lcd_vs", 32'(lcd_vs), 32'(vs_e));
      chk("lcd_rgb", 32'(lcd_rgb), 32'(rgb_e));
      if (stats_en) begin
         if (t >= 1 && t <= FRAME) begin
            de_cnt += int'(lcd_de);
            vs_cnt += int'(!lcd_vs);
         end
         if (t >= 1 && t <= H_T) hs_cnt += int'(!lcd_hs);
         if (!lcd_hs && hs_first < 0) hs_first = t;
         if (!lcd_vs && vs_first < 0) vs_first = t;
         if (frame_start) begin
            if (fs_first < 0) fs_first = t;
            else if (fs_second < 0) fs_second = t;
         end
      end
   endtask

   task automatic step();
      tp_prev = tp_used;
      tp_used = tp_drive;
      @(posedge clkin);
      @(negedge clkin);
      check_model();
      t++;
   endtask

   task automatic step_reset(input string tag);
      @(posedge clkin);
      @(negedge clkin);
      check_reset_vals(tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0; n_bad = 0; t = 0;
      tp_drive = 1'b0; tp_used = 1'b0; tp_prev = 1'b0;
      stats_en = 1'b0;
      de_cnt = 0; vs_cnt = 0; hs_cnt = 0;
      hs_first = -1; vs_first = -1; fs_first = -1; fs_second = -1;
      salt = 16'($urandom);
      resetn = 1'b1;

      // Power-on reset held for ten clocks.
      #1 resetn = 1'b0;
      #1 check_reset_vals("rst_async_on");
      repeat (10) step_reset("rst_hold");

      // Two complete frames plus a few cycles of the third.
      resetn = 1'b1;
      t = 0;
      stats_en = 1'b1;
      repeat (2 * FRAME + 8) step();
      stats_en = 1'b0;
      chk("de_cycles_per_frame", 32'(de_cnt), 32'(H_A * V_A));
      chk("vs_low_cycles", 32'(vs_cnt), 32'(V_S * H_T));
      chk("hs_low_cycles", 32'(hs_cnt), 32'(H_S));
      chk("hs_first_low", 32'(hs_first), 32'(H_A + H_F + 1));
      chk("vs_first_low", 32'(vs_first), 32'((V_A + V_F) * H_T + 1));
      chk("frame_first", 32'(fs_first), 32'd0);
      chk("frame_period", 32'(fs_second - fs_first), 32'(FRAME));

      // Asynchronous reset at a random point of the frame.
      target = int'($urandom_range(V_T - 1, 0)) * H_T + int'($urandom_range(H_T - 1, 0));
      for (int k = 0; k < FRAME && (t % FRAME) != target; k++) step();
      chk("reached_reset_point", 32'(t % FRAME), 32'(target));
      #2 resetn = 1'b0;
      #1 check_reset_vals("rst_async_mid");
      repeat (int'($urandom_range(4, 1))) step_reset("rst_mid_hold");
      resetn = 1'b1;
      t = 0;
      salt = 16'($urandom);
      repeat (2 * H_T + 20) step();

`ifdef RGB_LCD_TEST_PATTERN_EN
      // Colour bars, then random switching between bars and renderer data.
      tp_drive = 1'b1;
      repeat (2 * H_T) step();
      repeat (3 * H_T) begin
         if ($urandom_range(99, 0) == 0) tp_drive = ~tp_drive;
         step();
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
